// File: rtl/bist_pkg.sv
// Shared types and limits for the MBIST read-side comparator.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } cmp_state_t;

  localparam int MAX_RD_LAT = 4;

  // Drain timer width: must hold RD_LAT and still reach terminal count zero.
  function automatic int drain_cnt_w(input int rd_lat);
    return $clog2(rd_lat + 2);
  endfunction

endpackage

// File: rtl/bist_comparator_if.sv
// Read-compare strobe bus and result bus between BIST controller and comparator.
interface bist_comparator_if #(
  parameter int length     = 12,
  parameter int width      = 8,
  parameter int FAIL_CNT_W = 8
);

  logic                  start;
  logic                  rd_en;
  logic                  last;
  logic [length-1:0]     addr;
  logic [width-1:0]      exp_data;
  logic [width-1:0]      rd_data;
  logic                  busy;
  logic                  done;
  logic                  fail;
  logic [FAIL_CNT_W-1:0] fail_cnt;
  logic [length-1:0]     first_fail_addr;
  logic [width-1:0]      first_fail_diff;

  modport master (
    output start, rd_en, last, addr, exp_data, rd_data,
    input  busy, done, fail, fail_cnt, first_fail_addr, first_fail_diff
  );

  modport slave (
    input  start, rd_en, last, addr, exp_data, rd_data,
    output busy, done, fail, fail_cnt, first_fail_addr, first_fail_diff
  );

endinterface

// File: rtl/bist_delay_line.sv
// Valid-qualified shift register; clr flushes every valid bit in one cycle.
module bist_delay_line #(
  parameter int W     = 8,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [DEPTH-1:0][W-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid & ~clr;
    data_d[0]  = in_data;
    for (int i = 1; i < DEPTH; i++) begin
      valid_d[i] = valid_q[i-1] & ~clr;
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/bist_comparator.sv
// MBIST read-side response analyser: aligns read strobes to memory latency,
// XOR-compares returned data and accumulates pass/fail results.
//
// state | meaning
// IDLE  | after reset, waiting for start
// RUN   | accepting read strobes
// DRAIN | last read issued, flushing RD_LAT+1 cycles of compares
// DONE  | results stable until next start
module bist_comparator
  import bist_pkg::*;
#(
  parameter int length     = 12,
  parameter int width      = 8,
  parameter int RD_LAT     = 1,
  parameter int FAIL_CNT_W = 8
) (
  input logic              clk,
  input logic              reset,
  bist_comparator_if.slave bus
);

  localparam int DW = drain_cnt_w(RD_LAT);
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(RD_LAT);

  cmp_state_t state_q, state_d;
  logic [DW-1:0] drain_q, drain_d;

  logic                  fail_q, fail_d;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [length-1:0]     ffa_q, ffa_d;
  logic [width-1:0]      ffd_q, ffd_d;

  logic                    pipe_in_valid;
  logic                    pipe_out_valid;
  logic [length+width-1:0] pipe_out_data;
  logic [length-1:0]       cmp_addr;
  logic [width-1:0]        cmp_exp;
  logic [width-1:0]        cmp_diff;
  logic                    mismatch;

  // Strobes only enter the pipe in RUN; a start cycle never contributes.
  assign pipe_in_valid = bus.rd_en & (state_q == RUN) & ~bus.start;

  bist_delay_line #(
    .W     (length + width),
    .DEPTH (RD_LAT)
  ) u_pipe (
    .clk       (clk),
    .reset     (reset),
    .clr       (bus.start),
    .in_valid  (pipe_in_valid),
    .in_data   ({bus.addr, bus.exp_data}),
    .out_valid (pipe_out_valid),
    .out_data  (pipe_out_data)
  );

  assign {cmp_addr, cmp_exp} = pipe_out_data;
  assign cmp_diff = bus.rd_data ^ cmp_exp;
  assign mismatch = pipe_out_valid & (cmp_diff != '0);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    if (bus.start) begin
      state_d = RUN;
      drain_d = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.rd_en && bus.last) begin
            state_d = DRAIN;
            drain_d = DRAIN_LOAD;
          end
        end
        DRAIN: begin
          if (drain_q == '0) begin
            state_d = DONE;
          end else begin
            drain_d = drain_q - DW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fail_d     = fail_q;
    fail_cnt_d = fail_cnt_q;
    ffa_d      = ffa_q;
    ffd_d      = ffd_q;
    if (bus.start) begin
      fail_d     = 1'b0;
      fail_cnt_d = '0;
      ffa_d      = '0;
      ffd_d      = '0;
    end else if (mismatch) begin
      fail_d = 1'b1;
      if (!fail_q) begin
        ffa_d = cmp_addr;
        ffd_d = cmp_diff;
      end
      if (fail_cnt_q != '1) begin
        fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      drain_q    <= '0;
      fail_q     <= 1'b0;
      fail_cnt_q <= '0;
      ffa_q      <= '0;
      ffd_q      <= '0;
    end else begin
      state_q    <= state_d;
      drain_q    <= drain_d;
      fail_q     <= fail_d;
      fail_cnt_q <= fail_cnt_d;
      ffa_q      <= ffa_d;
      ffd_q      <= ffd_d;
    end
  end

  assign bus.busy            = (state_q == RUN) || (state_q == DRAIN);
  assign bus.done            = (state_q == DONE);
  assign bus.fail            = fail_q;
  assign bus.fail_cnt        = fail_cnt_q;
  assign bus.first_fail_addr = ffa_q;
  assign bus.first_fail_diff = ffd_q;

endmodule

// File: tb/tb_bist_comparator.sv
// Bench for bist_comparator: RD_LAT=1 and RD_LAT=3 instances share one stimulus
// stream; a cycle-level reference model is compared against both every cycle.
module tb_bist_comparator;

  localparam int N = 4096;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  bist_comparator_if #(.length(12), .width(8), .FAIL_CNT_W(8)) bus1 ();
  bist_comparator_if #(.length(12), .width(8), .FAIL_CNT_W(8)) bus3 ();

  bist_comparator #(.length(12), .width(8), .RD_LAT(1), .FAIL_CNT_W(8)) dut1 (
    .clk(clk), .reset(reset), .bus(bus1.slave));
  bist_comparator #(.length(12), .width(8), .RD_LAT(3), .FAIL_CNT_W(8)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave));

  int vecs = 0;
  int errs = 0;
  int cyc  = 0;

  // stimulus history indexed by cycle
  logic [7:0]  h_act  [N];
  logic [7:0]  h_diff [N];
  logic [11:0] h_addr [N];

  // model state per lane (0: latency 1, 1: latency 3); phase 0 idle,1 run,2 drain,3 done
  bit          acc    [2][N];
  int          clr_at [2];
  int          ph     [2];
  int          dend   [2];
  logic        m_fail [2];
  logic [7:0]  m_cnt  [2];
  logic [11:0] m_fa   [2];
  logic [7:0]  m_fd   [2];

  function automatic int lat_of(input int l);
    return (l == 0) ? 1 : 3;
  endfunction

  task automatic check(input string nm, input int l, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s lat%0d cyc %0d: got %0h expected %0h", nm, lat_of(l), cyc, act, exp);
    end
  endtask

  task automatic drive(input bit st, input bit rd, input bit ls,
                       input logic [11:0] a, input logic [7:0] e, input logic [7:0] act);
    int k = cyc % N;
    bus1.start = st;  bus3.start = st;
    bus1.rd_en = rd;  bus3.rd_en = rd;
    bus1.last  = ls;  bus3.last  = ls;
    bus1.addr  = a;   bus3.addr  = a;
    bus1.exp_data = e; bus3.exp_data = e;
    h_act[k]  = act;
    h_addr[k] = a;
    h_diff[k] = act ^ e;
    bus1.rd_data = (cyc >= 1) ? h_act[(cyc-1) % N] : 8'h00;
    bus3.rd_data = (cyc >= 3) ? h_act[(cyc-3) % N] : 8'h00;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 12'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic model_clear(input int l, input int c);
    m_fail[l] = 1'b0;
    m_cnt[l]  = 8'h00;
    m_fa[l]   = 12'h000;
    m_fd[l]   = 8'h00;
    clr_at[l] = c;
  endtask

  task automatic model_step(input int l, input int c);
    int L  = lat_of(l);
    int ic = c - L;
    acc[l][c % N] = 1'b0;
    if (!reset) begin
      model_clear(l, c);
      ph[l] = 0;
    end else if (bus1.start) begin
      model_clear(l, c);
      ph[l] = 1;
    end else begin
      // the read issued L cycles ago meets its data now
      if (ic >= 0 && ic > clr_at[l] && acc[l][ic % N] && h_diff[ic % N] != 8'h00) begin
        if (!m_fail[l]) begin
          m_fa[l] = h_addr[ic % N];
          m_fd[l] = h_diff[ic % N];
        end
        m_fail[l] = 1'b1;
        if (m_cnt[l] != 8'hFF) m_cnt[l] = m_cnt[l] + 8'h01;
      end
      if (ph[l] == 1) begin
        if (bus1.rd_en) begin
          acc[l][c % N] = 1'b1;
          if (bus1.last) begin
            ph[l]   = 2;
            dend[l] = c + L + 1;
          end
        end
      end else if (ph[l] == 2 && c == dend[l]) begin
        ph[l] = 3;
      end
    end
  endtask

  always @(posedge clk) begin
    for (int l = 0; l < 2; l++) model_step(l, cyc);
  end

  task automatic cmp_lane(input int l, input logic b, input logic d, input logic f,
                          input logic [7:0] cnt, input logic [11:0] fa, input logic [7:0] fd);
    logic eb, ed, ef;
    logic [7:0] ec, efd;
    logic [11:0] efa;
    eb = 1'b0; ed = 1'b0; ef = 1'b0; ec = 8'h00; efd = 8'h00; efa = 12'h000;
    if (reset) begin
      eb  = (ph[l] == 1) || (ph[l] == 2);
      ed  = (ph[l] == 3);
      ef  = m_fail[l];
      ec  = m_cnt[l];
      efa = m_fa[l];
      efd = m_fd[l];
    end
    check("busy", l, 32'(b), 32'(eb));
    check("done", l, 32'(d), 32'(ed));
    check("fail", l, 32'(f), 32'(ef));
    check("fail_cnt", l, 32'(cnt), 32'(ec));
    check("first_fail_addr", l, 32'(fa), 32'(efa));
    check("first_fail_diff", l, 32'(fd), 32'(efd));
  endtask

  always @(negedge clk) begin
    cmp_lane(0, bus1.busy, bus1.done, bus1.fail, bus1.fail_cnt, bus1.first_fail_addr, bus1.first_fail_diff);
    cmp_lane(1, bus3.busy, bus3.done, bus3.fail, bus3.fail_cnt, bus3.first_fail_addr, bus3.first_fail_diff);
  end

  // start, then n reads with background data and up to two injected faults
  task automatic run_seq(input int n, input logic [7:0] e, input logic [7:0] bg,
                         input int f1, input logic [7:0] a1, input int f2, input logic [7:0] a2);
    logic [7:0] act;
    drive(1'b1, 1'b1, 1'b0, 12'h000, e, ~e);
    for (int i = 0; i < n; i++) begin
      act = (i == f1) ? a1 : (i == f2) ? a2 : bg;
      drive(1'b0, 1'b1, i == n-1, 12'(i), e, act);
    end
  endtask

  // after last: done must appear exactly RD_LAT+2 cycles later, count already final
  task automatic drain_watch(input logic [7:0] cnt);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("lit_done", 0, 32'(bus1.done), 32'(k >= 3));
      check("lit_done", 1, 32'(bus3.done), 32'(k >= 5));
      check("lit_busy", 0, 32'(bus1.busy), 32'(k < 3));
      check("lit_busy", 1, 32'(bus3.busy), 32'(k < 5));
      if (k == 3) check("lit_cnt_at_done", 0, 32'(bus1.fail_cnt), 32'(cnt));
      if (k == 5) check("lit_cnt_at_done", 1, 32'(bus3.fail_cnt), 32'(cnt));
      idle();
    end
  endtask

  task automatic lit_both(input string nm, input logic [31:0] v1, input logic [31:0] v3, input logic [31:0] exp);
    check(nm, 0, v1, exp);
    check(nm, 1, v3, exp);
  endtask

  initial begin
    bit st, rd, ls;
    logic [7:0] e, act;

    repeat (3) idle();
    @(negedge clk);
    lit_both("lit_reset_busy", 32'(bus1.busy), 32'(bus3.busy), 0);
    lit_both("lit_reset_fail", 32'(bus1.fail), 32'(bus3.fail), 0);
    reset = 1'b1;
    repeat (2) idle();
    @(negedge clk);
    lit_both("lit_idle_done", 32'(bus1.done), 32'(bus3.done), 0);

    // all pass
    run_seq(256, 8'hAA, 8'hAA, -1, 8'h00, -1, 8'h00);
    drain_watch(8'h00);
    @(negedge clk);
    lit_both("lit_pass_fail", 32'(bus1.fail), 32'(bus3.fail), 0);
    lit_both("lit_pass_done", 32'(bus1.done), 32'(bus3.done), 1);

    // single fault
    run_seq(128, 8'hAA, 8'hAA, 'h5A, 8'hAE, -1, 8'h00);
    drain_watch(8'h01);
    @(negedge clk);
    lit_both("lit_single_fail", 32'(bus1.fail), 32'(bus3.fail), 1);
    lit_both("lit_single_addr", 32'(bus1.first_fail_addr), 32'(bus3.first_fail_addr), 32'h05A);
    lit_both("lit_single_diff", 32'(bus1.first_fail_diff), 32'(bus3.first_fail_diff), 32'h04);

    // two faults
    run_seq(16, 8'hAA, 8'hAA, 3, 8'hAB, 9, 8'h2A);
    drain_watch(8'h02);
    @(negedge clk);
    lit_both("lit_two_addr", 32'(bus1.first_fail_addr), 32'(bus3.first_fail_addr), 32'h003);
    lit_both("lit_two_diff", 32'(bus1.first_fail_diff), 32'(bus3.first_fail_diff), 32'h01);

    // saturation
    run_seq(300, 8'h00, 8'hFF, -1, 8'h00, -1, 8'h00);
    drain_watch(8'hFF);

    // mismatch only on the last read
    run_seq(10, 8'h55, 8'h55, 9, 8'h54, -1, 8'h00);
    drain_watch(8'h01);

    // restart mid-RUN after two fails
    drive(1'b1, 1'b0, 1'b0, 12'h000, 8'h00, 8'h00);
    for (int i = 0; i < 8; i++)
      drive(1'b0, 1'b1, 1'b0, 12'(i), 8'h33, (i == 1 || i == 2) ? 8'h32 : 8'h33);
    @(negedge clk);
    lit_both("lit_restart_pre_cnt", 32'(bus1.fail_cnt), 32'(bus3.fail_cnt), 2);
    drive(1'b1, 1'b1, 1'b0, 12'h000, 8'h33, 8'h00);
    @(negedge clk);
    lit_both("lit_restart_cnt", 32'(bus1.fail_cnt), 32'(bus3.fail_cnt), 0);
    lit_both("lit_restart_fail", 32'(bus1.fail), 32'(bus3.fail), 0);
    lit_both("lit_restart_busy", 32'(bus1.busy), 32'(bus3.busy), 1);
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b1, i == 3, 12'(i), 8'h33, 8'h33);
    drain_watch(8'h00);

    // reset mid-DRAIN, then strobes without start are ignored
    run_seq(5, 8'hC3, 8'hC3, 2, 8'hC0, -1, 8'h00);
    @(negedge clk);
    lit_both("lit_drain_busy", 32'(bus1.busy), 32'(bus3.busy), 1);
    idle();
    reset = 1'b0;
    @(negedge clk);
    lit_both("lit_rst_busy", 32'(bus1.busy), 32'(bus3.busy), 0);
    lit_both("lit_rst_done", 32'(bus1.done), 32'(bus3.done), 0);
    lit_both("lit_rst_fail", 32'(bus1.fail), 32'(bus3.fail), 0);
    repeat (2) idle();
    reset = 1'b1;
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, i == 5, 12'(i), 8'h0F, 8'hF0);
    repeat (4) idle();
    @(negedge clk);
    lit_both("lit_ignored_fail", 32'(bus1.fail), 32'(bus3.fail), 0);
    lit_both("lit_ignored_busy", 32'(bus1.busy), 32'(bus3.busy), 0);

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      st  = ($urandom % 48) == 0;
      rd  = ($urandom % 10) < 7;
      ls  = rd && (($urandom % 40) == 0);
      e   = 8'($urandom);
      act = (($urandom % 6) == 0) ? (e ^ 8'($urandom_range(1, 255))) : e;
      drive(st, rd, ls, 12'($urandom), e, act);
      if (($urandom % 700) == 0) begin
        reset = 1'b0;
        idle();
        reset = 1'b1;
      end
    end
    repeat (8) idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
